// File: rtl/rsa_modexp_sched.sv
// Sequential RSA decrypt scheduler: one word at a time, m = c^d mod N by left-to-right square-and-multiply
// on a shared bit-serial interleaved modular multiplier (NW cycles per modmul).
module rsa_modexp_sched #(
  parameter int NW = 16,
  parameter int EW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [NW-1:0] key_n,
  input  logic [EW-1:0] key_d,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_data,
  output logic          out_err,
  output logic          busy
);

  localparam int IW = (EW > 1) ? $clog2(EW) : 1;
  localparam int JW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SQR, S_MUL, S_OUT} state_t;

  state_t        state;
  logic          key_valid;
  logic [NW-1:0] n_r;
  logic [EW-1:0] d_r;
  logic [NW-1:0] c_r;
  logic [NW-1:0] res_r;
  logic [NW+1:0] acc;
  logic [JW-1:0] j_r;
  logic [IW-1:0] i_r;

  function automatic logic [IW-1:0] msb_idx(input logic [EW-1:0] v);
    msb_idx = '0;
    for (int k = 0; k < EW; k++)
      if (v[k]) msb_idx = IW'(k);
  endfunction

  // Multiplier operand b is the bit-serial side: res for squaring, c for the multiply step.
  logic [NW-1:0] mm_b;
  logic [NW+1:0] n_ext, t0, t1, t2;
  logic [NW-1:0] mm_res;
  logic [IW-1:0] d_msb;

  always_comb begin
    mm_b   = (state == S_MUL) ? c_r : res_r;
    n_ext  = {2'b00, n_r};
    t0     = (acc << 1) + (mm_b[j_r] ? {2'b00, res_r} : '0);
    t1     = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    t2     = (t1 >= n_ext) ? (t1 - n_ext) : t1;
    mm_res = t2[NW-1:0];
    d_msb  = msb_idx(d_r);
  end

  assign in_ready = (state == S_IDLE) && key_valid && !key_load;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_valid <= 1'b0;
      n_r       <= '0;
      d_r       <= '0;
      c_r       <= '0;
      res_r     <= '0;
      acc       <= '0;
      j_r       <= '0;
      i_r       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_load) begin
            n_r       <= key_n;
            d_r       <= key_d;
            key_valid <= 1'b1;
          end else if (in_valid && key_valid) begin
            c_r   <= in_data;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (n_r < NW'(2) || c_r >= n_r) begin
            out_valid <= 1'b1;
            out_data  <= '0;
            out_err   <= 1'b1;
            state     <= S_OUT;
          end else if (d_r == '0) begin
            out_valid <= 1'b1;
            out_data  <= NW'(1);
            out_err   <= 1'b0;
            state     <= S_OUT;
          end else begin
            res_r <= c_r;
            acc   <= '0;
            j_r   <= JW'(NW - 1);
            if (d_msb == '0) begin
              out_valid <= 1'b1;
              out_data  <= c_r;
              out_err   <= 1'b0;
              state     <= S_OUT;
            end else begin
              i_r   <= d_msb - 1'b1;
              state <= S_SQR;
            end
          end
        end
        S_SQR, S_MUL: begin
          if (j_r == '0) begin
            // Last multiplier cycle also makes the next-bit decision, so no idle step between modmuls.
            res_r <= mm_res;
            acc   <= '0;
            j_r   <= JW'(NW - 1);
            if (state == S_SQR && d_r[i_r]) begin
              state <= S_MUL;
            end else if (i_r == '0) begin
              out_valid <= 1'b1;
              out_data  <= mm_res;
              out_err   <= 1'b0;
              state     <= S_OUT;
            end else begin
              i_r   <= i_r - 1'b1;
              state <= S_SQR;
            end
          end else begin
            acc <= t2;
            j_r <= j_r - 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
